m_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. It replaces the free-running `r_pc <= w_npc` loop with an FSM that steps each instruction through fetch, decode, execute, memory and writeback, and shares a single memory port between instruction fetch and load/store. It drives the enable and select lines of the existing datapath pieces (adder, instruction/data memory, immediate generator, register file, operand mux), and keeps a retired-instruction counter.

---
 rtl/m_multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_m_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/m_multicycle_ctrl.sv
// m_multicycle_ctrl: multi-cycle sequencer for the RV32I core.
// Steps each instruction through IF/ID/EX/MEM/WB and shares one memory port
// between instruction fetch and load/store. It drives the datapath enables and
// selects, and keeps a wrapping count of retired instructions.
module m_multicycle_ctrl #(
    parameter int RETW = 32
) (
    input  logic            w_clk,
    input  logic            w_rst,
    input  logic            w_run,
    input  logic            w_mem_rdy,
    input  logic            w_r,
    input  logic            w_i,
    input  logic            w_s,
    input  logic            w_b,
    input  logic            w_u,
    input  logic            w_j,
    input  logic            w_ld,
    input  logic            w_taken,
    output logic            w_mem_req,
    output logic            w_mem_we,
    output logic            w_iord,
    output logic            w_ir_we,
    output logic            w_pc_we,
    output logic            w_pc_sel,
    output logic            w_alu_src,
    output logic            w_rf_we,
    output logic [1:0]      w_wb_sel,
    output logic [2:0]      w_state,
    output logic [RETW-1:0] w_retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_nstate;
    logic            r_pend;
    logic            w_npend;
    logic [RETW-1:0] r_retired;
    logic            w_retire;

    // Priority-resolved instruction class: load, store, branch, jump, then the rest.
    logic w_is_ld;
    logic w_is_st;
    logic w_is_br;
    logic w_is_j;
    logic w_legal;

    assign w_is_ld = w_ld;
    assign w_is_st = ~w_ld & w_s;
    assign w_is_br = ~w_ld & ~w_s & w_b;
    assign w_is_j  = ~w_ld & ~w_s & ~w_b & w_j;
    assign w_legal = w_r | w_i | w_s | w_b | w_u | w_j | w_ld;

    assign w_state   = r_state;
    assign w_retired = r_retired;

    // State, pending-fetch flag and retired counter; reset overrides every transition.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state   <= S_IF;
            r_pend    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_nstate;
            r_pend  <= w_npend;
            if (w_retire) begin
                r_retired <= r_retired + RETW'(1);
            end
        end
    end

    // Next-state and strobe decode; anything not driven in a state stays 0.
    always_comb begin
        w_nstate  = r_state;
        w_npend   = r_pend;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_iord    = 1'b0;
        w_ir_we   = 1'b0;
        w_pc_we   = 1'b0;
        w_pc_sel  = 1'b0;
        w_alu_src = 1'b0;
        w_rf_we   = 1'b0;
        w_wb_sel  = 2'b00;
        w_retire  = 1'b0;

        case (r_state)
            S_IF: begin
                // A started fetch is held through memory wait even if w_run drops.
                if (w_run || r_pend) begin
                    w_mem_req = 1'b1;
                    if (w_mem_rdy) begin
                        w_ir_we  = 1'b1;
                        w_npend  = 1'b0;
                        w_nstate = S_ID;
                    end else begin
                        w_npend = 1'b1;
                    end
                end
            end

            S_ID: begin
                w_nstate = w_legal ? S_EX : S_HALT;
            end

            S_EX: begin
                w_alu_src = ~(w_r | w_b);
                if (w_is_ld || w_is_st) begin
                    w_nstate = S_MEM;
                end else if (w_is_br) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = w_taken;
                    w_retire = 1'b1;
                    w_nstate = S_IF;
                end else begin
                    w_nstate = S_WB;
                end
            end

            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = w_is_st;
                w_alu_src = 1'b1;
                if (w_mem_rdy) begin
                    if (w_is_st) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_nstate = S_IF;
                    end else begin
                        w_nstate = S_WB;
                    end
                end
            end

            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_pc_sel = w_is_j;
                if (w_is_ld) begin
                    w_wb_sel = 2'b01;
                end else if (w_is_j) begin
                    w_wb_sel = 2'b10;
                end else begin
                    w_wb_sel = 2'b00;
                end
                w_retire = 1'b1;
                w_nstate = S_IF;
            end

            S_HALT: begin
                w_nstate = S_HALT;
            end

            default: begin
                w_nstate = S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// tb_m_multicycle_ctrl: directed and randomized bench for the multi-cycle sequencer.
// The model expands each instruction class into its expected per-cycle sequence of
// state and strobes; a narrow retired counter exercises wrap-around.
module tb_m_multicycle_ctrl;

    localparam int RETW = 4;

    localparam int C_R   = 0;
    localparam int C_I   = 1;
    localparam int C_S   = 2;
    localparam int C_B   = 3;
    localparam int C_U   = 4;
    localparam int C_J   = 5;
    localparam int C_LD  = 6;
    localparam int C_ILL = 7;

    logic            w_clk = 1'b0;
    logic            w_rst = 1'b0;
    logic            w_run = 1'b0;
    logic            w_mem_rdy = 1'b0;
    logic            w_r = 1'b0, w_i = 1'b0, w_s = 1'b0, w_b = 1'b0;
    logic            w_u = 1'b0, w_j = 1'b0, w_ld = 1'b0;
    logic            w_taken = 1'b0;
    logic            w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we, w_pc_sel;
    logic            w_alu_src, w_rf_we;
    logic [1:0]      w_wb_sel;
    logic [2:0]      w_state;
    logic [RETW-1:0] w_retired;

    int              n_cmp = 0;
    int              n_err = 0;
    int              cur_cls = C_ILL;
    bit              cur_taken = 1'b0;
    logic [RETW-1:0] exp_ret = '0;

    m_multicycle_ctrl #(.RETW(RETW)) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_run     (w_run),
        .w_mem_rdy (w_mem_rdy),
        .w_r       (w_r),
        .w_i       (w_i),
        .w_s       (w_s),
        .w_b       (w_b),
        .w_u       (w_u),
        .w_j       (w_j),
        .w_ld      (w_ld),
        .w_taken   (w_taken),
        .w_mem_req (w_mem_req),
        .w_mem_we  (w_mem_we),
        .w_iord    (w_iord),
        .w_ir_we   (w_ir_we),
        .w_pc_we   (w_pc_we),
        .w_pc_sel  (w_pc_sel),
        .w_alu_src (w_alu_src),
        .w_rf_we   (w_rf_we),
        .w_wb_sel  (w_wb_sel),
        .w_state   (w_state),
        .w_retired (w_retired)
    );

    always #5 w_clk = ~w_clk;

    // Expected observation: {state, req, we, iord, ir_we, pc_we, pc_sel, alu_src, rf_we, wb_sel}
    function automatic logic [12:0] mk(input int st, input bit req, input bit we, input bit iord,
                                       input bit irwe, input bit pcwe, input bit pcsel,
                                       input bit alus, input bit rfwe, input logic [1:0] wbsel);
        return {3'(st), req, we, iord, irwe, pcwe, pcsel, alus, rfwe, wbsel};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, well before the rising edge.
    task automatic step(input string tag, input bit run, input bit rdy, input bit rst,
                        input logic [12:0] e, input bit chk, input bit ret);
        logic [12:0] got;
        @(negedge w_clk);
        w_run     = run;
        w_mem_rdy = rdy;
        w_rst     = rst;
        w_taken   = cur_taken;
        w_r  = (cur_cls == C_R);
        w_i  = (cur_cls == C_I);
        w_s  = (cur_cls == C_S);
        w_b  = (cur_cls == C_B);
        w_u  = (cur_cls == C_U);
        w_j  = (cur_cls == C_J);
        w_ld = (cur_cls == C_LD);
        #1;
        if (chk) begin
            got = {w_state, w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we, w_pc_sel,
                   w_alu_src, w_rf_we, w_wb_sel};
            n_cmp++;
            assert (got === e) else begin
                n_err++;
                $error("FAIL %s strobes observed=%b expected=%b", tag, got, e);
            end
            n_cmp++;
            assert (w_retired === exp_ret) else begin
                n_err++;
                $error("FAIL %s retired observed=%0d expected=%0d", tag, w_retired, exp_ret);
            end
        end
        if (rst) exp_ret = '0;
        else if (ret) exp_ret = exp_ret + 1'b1;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step("reset", rb(), rb(), 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step("idle", 1'b0, rb(), 1'b0, mk(0,0,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
    endtask

    // Expands one instruction into its cycle-by-cycle expectation.
    // wf / wm: memory wait cycles in fetch / data access; drop forces w_run low after the fetch starts.
    task automatic run_instr(input int cls, input int wf, input int wm, input bit tk, input bit drop);
        bit rdy;
        bit st;
        bit alus;
        cur_cls   = cls;
        cur_taken = tk;
        for (int k = 0; k <= wf; k++) begin
            rdy = (k == wf);
            step("fetch", (k == 0) ? 1'b1 : (drop ? 1'b0 : rb()), rdy, 1'b0,
                 mk(0,1,0,0,rdy,0,0,0,0,2'b00), 1'b1, 1'b0);
        end
        step("decode", rb(), rb(), 1'b0, mk(1,0,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
        if (cls == C_ILL) return;
        alus = !(cls == C_R || cls == C_B);
        if (cls == C_B) begin
            step("branch", rb(), rb(), 1'b0, mk(2,0,0,0,0,1,tk,0,0,2'b00), 1'b1, 1'b1);
        end else if (cls == C_LD || cls == C_S) begin
            st = (cls == C_S);
            step("ex_mem", rb(), rb(), 1'b0, mk(2,0,0,0,0,0,0,1,0,2'b00), 1'b1, 1'b0);
            for (int k = 0; k <= wm; k++) begin
                rdy = (k == wm);
                step("mem", rb(), rdy, 1'b0, mk(3,1,st,1,0,st & rdy,0,1,0,2'b00), 1'b1, st & rdy);
            end
            if (!st) step("wb_load", rb(), rb(), 1'b0, mk(4,0,0,0,0,1,0,0,1,2'b01), 1'b1, 1'b1);
        end else begin
            step("ex", rb(), rb(), 1'b0, mk(2,0,0,0,0,0,0,alus,0,2'b00), 1'b1, 1'b0);
            step("wb", rb(), rb(), 1'b0,
                 mk(4,0,0,0,0,1,(cls == C_J),0,1,(cls == C_J) ? 2'b10 : 2'b00), 1'b1, 1'b1);
        end
    endtask

    initial begin
        // Reset and idle
        do_reset(2);
        idle(5);

        // R-type, zero-wait memory
        run_instr(C_R, 0, 0, 1'b0, 1'b0);
        idle(1);

        // Load with two wait cycles in MEM
        run_instr(C_LD, 0, 2, 1'b0, 1'b0);

        // Taken branch, then store, then a not-taken branch and a jump
        run_instr(C_B, 0, 0, 1'b1, 1'b0);
        run_instr(C_S, 0, 0, 1'b0, 1'b0);
        run_instr(C_B, 1, 0, 1'b0, 1'b0);
        run_instr(C_J, 0, 0, 1'b0, 1'b0);
        run_instr(C_I, 2, 0, 1'b0, 1'b0);
        run_instr(C_U, 0, 0, 1'b0, 1'b0);

        // Randomized legal instructions; enough retirements to wrap the counter
        for (int n = 0; n < 40; n++) begin
            run_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Illegal opcode parks in HALT until reset
        run_instr(C_ILL, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++)
            step("halt", rb(), rb(), 1'b0, mk(5,0,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
        do_reset(1);
        idle(3);

        // Reset during MEM wait, then a late w_mem_rdy is ignored
        run_instr(C_R, 0, 0, 1'b0, 1'b0);
        cur_cls = C_LD;
        step("rst_fetch", 1'b1, 1'b1, 1'b0, mk(0,1,0,0,1,0,0,0,0,2'b00), 1'b1, 1'b0);
        step("rst_decode", 1'b0, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
        step("rst_ex", 1'b0, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,1,0,2'b00), 1'b1, 1'b0);
        step("rst_memwait", 1'b0, 1'b0, 1'b0, mk(3,1,0,1,0,0,0,1,0,2'b00), 1'b1, 1'b0);
        do_reset(1);
        step("late_rdy", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
        idle(3);

        // w_run dropped after the fetch started: request held until w_mem_rdy
        run_instr(C_S, 3, 1, 1'b0, 1'b1);
        run_instr(C_LD, 2, 0, 1'b0, 1'b1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
